// File: rtl/i2s_tx_master.sv
// Clock-master I2S transmitter: divides clk into bclk/lrclk and
// shifts stereo PCM pairs from a small FIFO out in 32-bit slots.
module i2s_tx_master #(
  parameter int BCLK_DIV   = 4,
  parameter int DATA_BITS  = 24,
  parameter int FIFO_DEPTH = 4,
  localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 audio_en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] l_data,
  input  logic [DATA_BITS-1:0] r_data,
  output logic                 bclk,
  output logic                 lrclk,
  output logic                 s_data,
  output logic                 frame_strobe,
  output logic                 underrun,
  output logic [LVL_W-1:0]     fifo_level
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCLK_DIV - 1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(FIFO_DEPTH);

  logic [2*DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [LVL_W-1:0]       lvl_q, lvl_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [5:0]             pos_q, pos_d, pos_n;
  logic                   bclk_q, bclk_d;
  logic                   lr_q, lr_d;
  logic                   sd_q, sd_d;
  logic                   stb_q, stb_d;
  logic                   und_q, und_d;
  logic [DATA_BITS-1:0]   l_q, l_d, r_q, r_d;
  logic                   tick, fall, load, push, pop;

  // Slot position 0 is the I2S one-bit delay; bits past the sample pad with 0.
  function automatic logic slot_bit(
    input logic [5:0]           pos,
    input logic [DATA_BITS-1:0] l,
    input logic [DATA_BITS-1:0] r
  );
    logic [DATA_BITS-1:0] w;
    logic [IDX_W-1:0]     idx;
    int                   p;
    w   = pos[5] ? r : l;
    p   = int'(pos[4:0]);
    idx = IDX_W'(DATA_BITS - p);
    if (p >= 1 && p <= DATA_BITS) return w[idx];
    return 1'b0;
  endfunction

  assign tick     = (div_q == DIV_MAX);
  assign fall     = tick && bclk_q;
  assign pos_n    = pos_q + 6'd1;
  assign load     = fall && (pos_n == 6'd0);
  assign pop      = load && (lvl_q != '0);
  assign in_ready = audio_en && !reset && (lvl_q < LVL_MAX);
  assign push     = in_valid && in_ready;

  always_comb begin
    div_d  = div_q;
    bclk_d = bclk_q;
    pos_d  = pos_q;
    lr_d   = lr_q;
    sd_d   = sd_q;
    stb_d  = 1'b0;
    und_d  = und_q;
    l_d    = l_q;
    r_d    = r_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    lvl_d  = lvl_q;
    if (!audio_en) begin
      div_d  = '0;
      bclk_d = 1'b0;
      pos_d  = 6'd63;
      lr_d   = 1'b0;
      sd_d   = 1'b0;
      und_d  = 1'b0;
      wr_d   = '0;
      rd_d   = '0;
      lvl_d  = '0;
    end else begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (tick) bclk_d = !bclk_q;
      stb_d = load;
      if (load) begin
        l_d   = pop ? mem_q[rd_q][2*DATA_BITS-1:DATA_BITS] : '0;
        r_d   = pop ? mem_q[rd_q][DATA_BITS-1:0] : '0;
        und_d = und_q || !pop;
      end
      if (fall) begin
        pos_d = pos_n;
        lr_d  = pos_n[5];
        sd_d  = slot_bit(pos_n, l_d, r_d);
      end
      if (push) wr_d = wr_q + PTR_W'(1);
      if (pop)  rd_d = rd_q + PTR_W'(1);
      lvl_d = lvl_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
      pos_q  <= 6'd63;
      lr_q   <= 1'b0;
      sd_q   <= 1'b0;
      stb_q  <= 1'b0;
      und_q  <= 1'b0;
      l_q    <= '0;
      r_q    <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      lvl_q  <= '0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
      pos_q  <= pos_d;
      lr_q   <= lr_d;
      sd_q   <= sd_d;
      stb_q  <= stb_d;
      und_q  <= und_d;
      l_q    <= l_d;
      r_q    <= r_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      lvl_q  <= lvl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {l_data, r_data};
  end

  assign bclk         = bclk_q;
  assign lrclk        = lr_q;
  assign s_data       = sd_q;
  assign frame_strobe = stb_q;
  assign underrun     = und_q;
  assign fifo_level   = lvl_q;

endmodule

// File: tb/tb_i2s_tx_master.sv
// Directed bench for i2s_tx_master with BCLK_DIV=2, FIFO_DEPTH=4.
// Frames are captured MSB-first at each bclk rising edge.
module tb_i2s_tx_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        audio_en = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] l_data = '0;
  logic [23:0] r_data = '0;
  logic        bclk, lrclk, s_data, frame_strobe, underrun;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] LR_EXP = {32'h0, 32'hFFFF_FFFF};

  i2s_tx_master #(
    .BCLK_DIV(2),
    .DATA_BITS(24),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .audio_en(audio_en),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .l_data(l_data),
    .r_data(r_data),
    .bclk(bclk),
    .lrclk(lrclk),
    .s_data(s_data),
    .frame_strobe(frame_strobe),
    .underrun(underrun),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic go_idle();
    audio_en = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_strobe(input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc && n < 0; i++) begin
      @(negedge clk);
      if (frame_strobe) n = i;
    end
  endtask

  // Starts on the negedge where frame_strobe is seen.
  task automatic capture(output logic [63:0] sd, output logic [63:0] lr,
                         output bit ok);
    logic pb;
    int   got;
    int   cyc;
    sd  = '0;
    lr  = '0;
    got = 0;
    cyc = 0;
    pb  = bclk;
    while (got < 64 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bclk && !pb) begin
        sd = {sd[62:0], s_data};
        lr = {lr[62:0], lrclk};
        got++;
      end
      pb = bclk;
    end
    ok = (got == 64);
  endtask

  task automatic test_reset();
    audio_en = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bclk, lrclk, s_data, frame_strobe, underrun, in_ready} !== 6'b0) begin
      errors++;
      $display("FAIL rst_outs got %b exp 000000",
               {bclk, lrclk, s_data, frame_strobe, underrun, in_ready});
    end
    checks++;
    if (fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL rst_level got %0d exp 0", fifo_level);
    end
    audio_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bclk, lrclk, s_data, in_ready} !== 4'b0) begin
      errors++;
      $display("FAIL idle_outs got %b exp 0000",
               {bclk, lrclk, s_data, in_ready});
    end
  endtask

  task automatic test_basic();
    int n;
    logic [63:0] sd, lr;
    bit ok;
    go_idle();
    audio_en = 1'b1;
    in_valid = 1'b1;
    l_data   = 24'hA5A5A5;
    r_data   = 24'h5A5A5A;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (fifo_level !== 3'd1 || bclk !== 1'b0) begin
      errors++;
      $display("FAIL basic_c1 got lvl %0d bclk %b exp 1 0", fifo_level, bclk);
    end
    @(negedge clk);
    checks++;
    if (bclk !== 1'b1) begin
      errors++;
      $display("FAIL basic_bclk_rise got %b exp 1", bclk);
    end
    @(negedge clk);
    checks++;
    if (frame_strobe !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_strobe got %b exp 0", frame_strobe);
    end
    @(negedge clk);
    checks++;
    if (frame_strobe !== 1'b1 || fifo_level !== 3'd0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL basic_load got stb %b lvl %0d und %b exp 1 0 0",
               frame_strobe, fifo_level, underrun);
    end
    capture(sd, lr, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_capture got timeout exp 64 bits");
    end
    checks++;
    if (sd !== {1'b0, 24'hA5A5A5, 7'h0, 1'b0, 24'h5A5A5A, 7'h0}) begin
      errors++;
      $display("FAIL basic_sdata got %h exp %h", sd,
               {1'b0, 24'hA5A5A5, 7'h0, 1'b0, 24'h5A5A5A, 7'h0});
    end
    checks++;
    if (lr !== LR_EXP) begin
      errors++;
      $display("FAIL basic_lrclk got %h exp %h", lr, LR_EXP);
    end
    wait_strobe(300, n);
    wait_strobe(300, n);
    checks++;
    if (n !== 256) begin
      errors++;
      $display("FAIL basic_frame_period got %0d exp 256", n);
    end
  endtask

  task automatic test_underrun();
    int n;
    logic [63:0] sd, lr;
    bit ok;
    go_idle();
    checks++;
    if ({underrun, in_ready, lrclk, bclk} !== 4'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL und_idle got %b lvl %0d exp 0000 0",
               {underrun, in_ready, lrclk, bclk}, fifo_level);
    end
    audio_en = 1'b1;
    wait_strobe(20, n);
    checks++;
    if (n !== 4 || underrun !== 1'b1) begin
      errors++;
      $display("FAIL und_first got n %0d und %b exp 4 1", n, underrun);
    end
    capture(sd, lr, ok);
    checks++;
    if (!ok || sd !== 64'h0 || lr !== LR_EXP) begin
      errors++;
      $display("FAIL und_zero_frame got ok %b sd %h lr %h exp 1 0 %h",
               ok, sd, lr, LR_EXP);
    end
    wait_strobe(300, n);
    repeat (50) @(negedge clk);
    in_valid = 1'b1;
    l_data   = 24'h123456;
    r_data   = 24'h654321;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (fifo_level !== 3'd1) begin
      errors++;
      $display("FAIL und_push_level got %0d exp 1", fifo_level);
    end
    wait_strobe(300, n);
    checks++;
    if (n < 0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL und_pop got n %0d lvl %0d exp >0 0", n, fifo_level);
    end
    capture(sd, lr, ok);
    checks++;
    if (!ok || sd !== {1'b0, 24'h123456, 7'h0, 1'b0, 24'h654321, 7'h0}) begin
      errors++;
      $display("FAIL und_data got %h exp %h", sd,
               {1'b0, 24'h123456, 7'h0, 1'b0, 24'h654321, 7'h0});
    end
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL und_sticky got %b exp 1", underrun);
    end
  endtask

  task automatic test_fifo_full();
    int n;
    int pushes;
    go_idle();
    audio_en = 1'b1;
    wait_strobe(20, n);
    in_valid = 1'b1;
    l_data   = 24'h111111;
    r_data   = 24'h222222;
    pushes   = 0;
    repeat (8) begin
      if (in_ready) pushes++;
      @(negedge clk);
    end
    checks++;
    if (pushes !== 4 || fifo_level !== 3'd4 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_fill got pushes %0d lvl %0d rdy %b exp 4 4 0",
               pushes, fifo_level, in_ready);
    end
    wait_strobe(300, n);
    checks++;
    if (fifo_level !== 3'd3 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_after_pop got lvl %0d rdy %b exp 3 1",
               fifo_level, in_ready);
    end
    @(negedge clk);
    checks++;
    if (fifo_level !== 3'd4 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_refill got lvl %0d rdy %b exp 4 0",
               fifo_level, in_ready);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (fifo_level !== 3'd4) begin
      errors++;
      $display("FAIL full_hold got lvl %0d exp 4", fifo_level);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_full_scale();
    int n;
    logic [63:0] sd, lr;
    bit ok;
    go_idle();
    audio_en = 1'b1;
    in_valid = 1'b1;
    l_data   = 24'h800000;
    r_data   = 24'h7FFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    wait_strobe(20, n);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL fs_latency got %0d exp 3", n);
    end
    capture(sd, lr, ok);
    checks++;
    if (!ok || sd !== {1'b0, 24'h800000, 7'h0, 1'b0, 24'h7FFFFF, 7'h0}) begin
      errors++;
      $display("FAIL fs_frame got %h exp %h", sd,
               {1'b0, 24'h800000, 7'h0, 1'b0, 24'h7FFFFF, 7'h0});
    end
    checks++;
    if ({sd[62], sd[61], sd[30], sd[29]} !== 4'b1001) begin
      errors++;
      $display("FAIL fs_edges got %b exp 1001",
               {sd[62], sd[61], sd[30], sd[29]});
    end
  endtask

  task automatic test_enable_drop();
    int n;
    go_idle();
    audio_en = 1'b1;
    wait_strobe(20, n);
    in_valid = 1'b1;
    l_data   = 24'h0000AA;
    r_data   = 24'h0000BB;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (158) @(negedge clk);
    checks++;
    if (lrclk !== 1'b1 || fifo_level !== 3'd2 || underrun !== 1'b1) begin
      errors++;
      $display("FAIL drop_pre got lr %b lvl %0d und %b exp 1 2 1",
               lrclk, fifo_level, underrun);
    end
    audio_en = 1'b0;
    @(negedge clk);
    checks++;
    if ({bclk, lrclk, s_data, underrun, in_ready} !== 5'b0 ||
        fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL drop_idle got %b lvl %0d exp 00000 0",
               {bclk, lrclk, s_data, underrun, in_ready}, fifo_level);
    end
    audio_en = 1'b1;
    wait_strobe(20, n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL drop_reenable got %0d exp 4", n);
    end
  endtask

  task automatic test_async_reset();
    int n;
    logic [63:0] sd, lr;
    bit ok;
    go_idle();
    audio_en = 1'b1;
    wait_strobe(20, n);
    in_valid = 1'b1;
    l_data   = 24'h777777;
    r_data   = 24'h888888;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (141) @(negedge clk);
    checks++;
    if ({bclk, lrclk, underrun} !== 3'b111 || fifo_level !== 3'd1) begin
      errors++;
      $display("FAIL arst_pre got %b lvl %0d exp 111 1",
               {bclk, lrclk, underrun}, fifo_level);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bclk, lrclk, s_data, frame_strobe, underrun, in_ready} !== 6'b0 ||
        fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL arst_async got %b lvl %0d exp 000000 0",
               {bclk, lrclk, s_data, frame_strobe, underrun, in_ready},
               fifo_level);
    end
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b1;
    l_data   = 24'h0F0F0F;
    r_data   = 24'hF0F0F0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_strobe(20, n);
    checks++;
    if (n !== 3 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL arst_restart got n %0d und %b exp 3 0", n, underrun);
    end
    capture(sd, lr, ok);
    checks++;
    if (!ok || lr !== LR_EXP ||
        sd !== {1'b0, 24'h0F0F0F, 7'h0, 1'b0, 24'hF0F0F0, 7'h0}) begin
      errors++;
      $display("FAIL arst_frame got sd %h lr %h exp %h %h", sd, lr,
               {1'b0, 24'h0F0F0F, 7'h0, 1'b0, 24'hF0F0F0, 7'h0}, LR_EXP);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_fifo_full();
    test_full_scale();
    test_enable_drop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
